// File: rtl/debug_access_port.sv
// Debug responder: halts the core, performs one register-file or data-memory word access, returns a response.
// All outputs registered; one request outstanding; response held until resp_ready.
module debug_access_port #(
  parameter int MEM_BYTES    = 1024,
  parameter int HALT_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_space,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        halt_req,
  input  logic        halted,
  output logic [4:0]  rf_addr,
  output logic        rf_we,
  output logic [31:0] rf_wdata,
  input  logic [31:0] rf_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int              CW       = $clog2(HALT_TIMEOUT + 1);
  localparam logic [CW-1:0]   TMO      = CW'(HALT_TIMEOUT);
  localparam logic [31:0]     MEM_LAST = 32'(MEM_BYTES - 4);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HALT_WAIT = 3'd1,
    ACCESS    = 3'd2,
    MEM_WAIT  = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, write_d;
  logic          space_q, space_d;
  logic [4:0]    rf_addr_q, rf_addr_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;
  logic          halt_req_q, halt_req_d;
  logic          rf_we_q, rf_we_d;
  logic          mem_we_q, mem_we_d;
  logic          req_err;

  always_comb begin
    req_err = 1'b0;
    if (!req_space) begin
      req_err = (req_addr > 32'd31);
    end else begin
      req_err = (req_addr[1:0] != 2'b00) || (req_addr > MEM_LAST);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    space_d      = space_q;
    rf_addr_d    = rf_addr_q;
    mem_addr_d   = mem_addr_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    halt_req_d   = halt_req_q;
    rf_we_d      = 1'b0;
    mem_we_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d      = req_write;
          space_d      = req_space;
          rf_addr_d    = req_addr[4:0];
          mem_addr_d   = {req_addr[31:2], 2'b00};
          wdata_d      = req_wdata;
          req_ready_d  = 1'b0;
          resp_rdata_d = 32'd0;
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d    = HALT_WAIT;
            halt_req_d = 1'b1;
            cnt_d      = '0;
          end
        end
      end
      HALT_WAIT: begin
        // Strobes are launched here so they land in the ACCESS cycle, after halt is confirmed.
        if (halted) begin
          state_d = ACCESS;
          if (write_q) begin
            if (space_q)                mem_we_d = 1'b1;
            else if (rf_addr_q != 5'd0) rf_we_d  = 1'b1;
          end
        end else if (cnt_q == TMO) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACCESS: begin
        if (space_q && !write_q) begin
          state_d = MEM_WAIT;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          if (!space_q && !write_q) begin
            resp_rdata_d = (rf_addr_q == 5'd0) ? 32'd0 : rf_rdata;
          end
        end
      end
      MEM_WAIT: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = mem_rdata;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'd0;
          resp_err_d   = 1'b0;
          halt_req_d   = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        halt_req_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      space_q      <= 1'b0;
      rf_addr_q    <= 5'd0;
      mem_addr_q   <= 32'd0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      halt_req_q   <= 1'b0;
      rf_we_q      <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      space_q      <= space_d;
      rf_addr_q    <= rf_addr_d;
      mem_addr_q   <= mem_addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      halt_req_q   <= halt_req_d;
      rf_we_q      <= rf_we_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign halt_req   = halt_req_q;
  assign rf_addr    = rf_addr_q;
  assign rf_we      = rf_we_q;
  assign rf_wdata   = wdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_debug_access_port.sv
// Randomized bench for debug_access_port: core-side register/memory/halt models plus a shadow reference.
module tb_debug_access_port;
  localparam int MEM_BYTES = 1024;
  localparam int HT        = 16;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        req_valid, req_ready, req_write, req_space;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        halt_req, halted;
  logic [4:0]  rf_addr;
  logic        rf_we, mem_we;
  logic [31:0] rf_wdata, rf_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] rf_m   [32];
  logic [7:0]  mem_b  [MEM_BYTES];
  logic [31:0] exp_rf [32];
  logic [7:0]  exp_mem[MEM_BYTES];

  int   halt_delay;
  logic halt_stuck;
  int   hcnt;
  int   ma;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  debug_access_port #(.MEM_BYTES(MEM_BYTES), .HALT_TIMEOUT(HT)) dut (
    .CLK(CLK), .Reset_n(Reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_space(req_space), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .halt_req(halt_req), .halted(halted),
    .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Core model: halted follows halt_req after halt_delay cycles unless stuck.
  assign rf_rdata = rf_m[rf_addr];
  assign halted   = halt_req && !halt_stuck && (hcnt >= halt_delay);

  always @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n)      hcnt <= 0;
    else if (halt_req) hcnt <= hcnt + 1;
    else               hcnt <= 0;
  end

  always @(posedge CLK) begin
    ma = int'(mem_addr[9:0]);
    if (rf_we) rf_m[rf_addr] <= rf_wdata;
    if (mem_we) begin
      mem_b[ma]   <= mem_wdata[7:0];
      mem_b[ma+1] <= mem_wdata[15:8];
      mem_b[ma+2] <= mem_wdata[23:16];
      mem_b[ma+3] <= mem_wdata[31:24];
    end
    mem_rdata <= {mem_b[ma+3], mem_b[ma+2], mem_b[ma+1], mem_b[ma]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int a);
    return {exp_mem[a+3], exp_mem[a+2], exp_mem[a+1], exp_mem[a]};
  endfunction

  task automatic chk_reset_vals(input string p);
    chk({p, "_req_ready"},  req_ready,  1);
    chk({p, "_resp_valid"}, resp_valid, 0);
    chk({p, "_resp_rdata"}, resp_rdata, 0);
    chk({p, "_resp_err"},   resp_err,   0);
    chk({p, "_halt_req"},   halt_req,   0);
    chk({p, "_strobes"},    {30'd0, rf_we, mem_we}, 0);
    chk({p, "_rf_addr"},    rf_addr,    0);
    chk({p, "_mem_addr"},   mem_addr,   0);
    chk({p, "_wdata"},      rf_wdata | mem_wdata, 0);
  endtask

  task automatic run(input logic w, input logic sp, input logic [31:0] addr,
                     input logic [31:0] wd, input int d, input logic stuck, input int hold);
    logic        bad, exp_err;
    logic [31:0] exp_rd, strobe_addr;
    int          exp_lat, lat, rf_cnt, mem_cnt, unh, hr_high;
    bad     = sp ? ((addr % 4) != 0 || addr > 32'(MEM_BYTES - 4)) : (addr > 31);
    exp_err = bad || stuck;
    exp_lat = bad ? 1 : stuck ? HT + 2 : (sp && !w) ? 4 + d : 3 + d;
    exp_rd  = 0;
    if (!exp_err && !w) exp_rd = sp ? exp_word(int'(addr)) : (addr == 0 ? 32'd0 : exp_rf[addr[4:0]]);
    if (!exp_err && w) begin
      if (sp) for (int b = 0; b < 4; b++) exp_mem[int'(addr) + b] = wd[8*b +: 8];
      else if (addr != 0) exp_rf[addr[4:0]] = wd;
    end

    halt_delay = d;
    halt_stuck = stuck;
    @(negedge CLK);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_write = w; req_space = sp; req_addr = addr; req_wdata = wd;
    @(posedge CLK);
    #1 req_valid = 0;
    lat = 0; rf_cnt = 0; mem_cnt = 0; unh = 0; hr_high = 0; strobe_addr = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      if (halt_req) hr_high++;
      if (rf_we)  begin rf_cnt++;  strobe_addr = 32'(rf_addr); if (!halted) unh++; end
      if (mem_we) begin mem_cnt++; strobe_addr = mem_addr;     if (!halted) unh++; end
      if (resp_valid) begin lat = k; break; end
    end
    chk("latency",     lat,        exp_lat);
    chk("resp_err",    resp_err,   exp_err);
    chk("resp_rdata",  resp_rdata, exp_rd);
    chk("halt_cycles", hr_high,    bad ? 0 : lat);
    chk("rf_we_count", rf_cnt,     (w && !sp && !exp_err && addr != 0) ? 1 : 0);
    chk("mem_we_count", mem_cnt,   (w && sp && !exp_err) ? 1 : 0);
    chk("we_unhalted", unh, 0);
    if (w && !exp_err && (sp || addr != 0)) chk("strobe_addr", strobe_addr, addr);
    if (lat == 0) begin
      Reset_n = 0; #1; @(negedge CLK); Reset_n = 1;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      chk("hold_resp_valid", resp_valid, 1);
      chk("hold_resp_rdata", resp_rdata, exp_rd);
      chk("hold_req_ready",  req_ready,  0);
      chk("hold_halt_req",   halt_req,   bad ? 0 : 1);
    end
    resp_ready = 1;
    @(posedge CLK);
    #1 resp_ready = 0;
    @(negedge CLK);
    chk("post_req_ready",  req_ready,  1);
    chk("post_resp_valid", resp_valid, 0);
    chk("post_halt_req",   halt_req,   0);
  endtask

  initial begin
    logic        w, sp, stuck;
    logic [31:0] addr, wd;
    int          sel, diffs;
    Reset_n = 0; req_valid = 0; req_write = 0; req_space = 0; req_addr = 0; req_wdata = 0;
    resp_ready = 0; halt_delay = 0; halt_stuck = 0;
    for (int i = 0; i < 32; i++) begin rf_m[i] = 0; exp_rf[i] = 0; end
    for (int i = 0; i < MEM_BYTES; i++) begin mem_b[i] = 0; exp_mem[i] = 0; end
    rf_m[3] = 32'd8; exp_rf[3] = 32'd8;
    repeat (3) @(negedge CLK);
    chk_reset_vals("reset");
    Reset_n = 1;

    run(0, 0, 3, 0, 0, 0, 0);
    run(1, 0, 5, 1, 0, 0, 0);
    run(0, 0, 5, 0, 0, 0, 0);
    run(1, 0, 0, 32'hFFFF_FFFF, 0, 0, 0);
    run(0, 0, 0, 0, 0, 0, 0);
    run(1, 1, 0, 8, 0, 0, 0);
    chk("ram_b0", mem_b[0], 8'h08);
    chk("ram_b1", mem_b[1], 8'h00);
    chk("ram_b2", mem_b[2], 8'h00);
    chk("ram_b3", mem_b[3], 8'h00);
    run(0, 1, 0, 0, 0, 0, 0);
    run(1, 1, 1020, 32'hA1B2_C3D4, 0, 0, 0);
    run(0, 1, 1020, 0, 0, 0, 0);
    run(1, 1, 2, 32'h1234_5678, 0, 0, 0);
    run(0, 1, MEM_BYTES, 0, 0, 0, 0);
    run(1, 0, 32, 32'h5555_5555, 0, 0, 0);
    run(0, 0, 5, 0, 5, 0, 0);
    run(1, 0, 7, 32'hDEAD_BEEF, 0, 1, 0);
    run(0, 0, 3, 0, 0, 0, 10);

    // Reset while waiting for halt: nothing may be written and outputs drop at once.
    halt_delay = 0; halt_stuck = 1;
    @(negedge CLK);
    req_valid = 1; req_write = 1; req_space = 0; req_addr = 9; req_wdata = 32'h0BAD_0BAD;
    @(posedge CLK);
    #1 req_valid = 0;
    repeat (3) @(posedge CLK);
    #1 Reset_n = 0;
    #1 chk_reset_vals("midreset");
    @(negedge CLK);
    Reset_n = 1; halt_stuck = 0;
    run(0, 0, 9, 0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      w   = 1'($urandom_range(0, 1));
      sp  = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (!sp) addr = (sel == 0) ? 32 + $urandom_range(0, 200) : $urandom_range(0, 31);
      else if (sel == 0) addr = 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      else if (sel == 1) addr = MEM_BYTES + 4 * $urandom_range(0, 50);
      else addr = 4 * $urandom_range(0, 15);
      wd    = $urandom;
      stuck = ($urandom_range(0, 11) == 0);
      run(w, sp, addr, wd, int'($urandom_range(0, 3)), stuck, int'($urandom_range(0, 3)));
    end

    diffs = 0;
    for (int i = 0; i < 32; i++) if (rf_m[i] !== exp_rf[i]) diffs++;
    chk("rf_image_diffs", diffs, 0);
    diffs = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem_b[i] !== exp_mem[i]) diffs++;
    chk("mem_image_diffs", diffs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
